// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the IF stage: FSM states, halt opcode, PC reset value, IF/ID word layout.
package if_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STEP,
        HALT
    } fsm_state_t;

    localparam logic [5:0]  HALT_OPCODE_DEF = 6'h3F;
    localparam int unsigned PC_RESET        = 0;

    localparam int unsigned IFID_PC4_HI   = 63;
    localparam int unsigned IFID_PC4_LO   = 32;
    localparam int unsigned IFID_INSTR_HI = 31;
    localparam int unsigned IFID_INSTR_LO = 0;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// IF stage bus: debug run-control, program load, hazard/redirect inputs and the IF/ID-facing outputs.
interface instruction_fetch_unit_if #(
    parameter int unsigned PC_W    = 32,
    parameter int unsigned IMEM_AW = 8
);
    logic               cmd_run;
    logic               cmd_step;
    logic               cmd_stop;
    logic               load_we;
    logic [IMEM_AW-1:0] load_addr;
    logic [31:0]        load_data;
    logic               stall;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic [63:0]        if_id_data;
    logic               if_id_we;
    logic               if_id_flush;
    logic [PC_W-1:0]    pc;
    logic               halted;
    logic [31:0]        fetch_count;

    modport master (
        output cmd_run, cmd_step, cmd_stop, load_we, load_addr, load_data,
               stall, redirect_valid, redirect_pc,
        input  if_id_data, if_id_we, if_id_flush, pc, halted, fetch_count
    );

    modport slave (
        input  cmd_run, cmd_step, cmd_stop, load_we, load_addr, load_data,
               stall, redirect_valid, redirect_pc,
        output if_id_data, if_id_we, if_id_flush, pc, halted, fetch_count
    );
endinterface

// File: rtl/instruction_fetch_unit_instr_mem.sv
// Program memory: synchronous write, combinational read, 2**AW 32-bit words; contents survive reset.
module instr_mem #(
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS IF stage: PC, program memory and debug run-control FSM.
// Optional fetch counter built only when IF_FETCH_CNT_EN is defined; otherwise fetch_count reads 0.
module instruction_fetch_unit
    import if_pkg::*;
#(
    parameter int unsigned PC_W        = 32,
    parameter int unsigned IMEM_AW     = 8,
    parameter logic [5:0]  HALT_OPCODE = HALT_OPCODE_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    instruction_fetch_unit_if.slave  bus
);

    fsm_state_t      state;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_plus4;
    logic [31:0]     instr;
    logic            halted_q;
    logic            active;
    logic            redir;
    logic            adv;
    logic            halt_hit;

    assign pc_plus4 = pc_q + PC_W'(4);
    assign active   = (state == RUN) || (state == STEP);
    assign redir    = active && bus.redirect_valid;
    assign adv      = active && !bus.stall && !bus.redirect_valid;
    assign halt_hit = adv && (instr[31:26] == HALT_OPCODE);

    instr_mem #(.AW(IMEM_AW)) u_mem (
        .clk   (clk),
        .we    (bus.load_we && (state == IDLE)),
        .waddr (bus.load_addr),
        .wdata (bus.load_data),
        .raddr (pc_q[IMEM_AW+1:2]),
        .rdata (instr)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            pc_q     <= PC_W'(PC_RESET);
            halted_q <= 1'b0;
        end else begin
            // Redirect outranks both stall and halt; a halt fetch leaves pc on the halt word.
            if (redir)
                pc_q <= bus.redirect_pc;
            else if (adv && !halt_hit)
                pc_q <= pc_plus4;

            unique case (state)
                IDLE: begin
                    if (bus.cmd_run)       state <= RUN;
                    else if (bus.cmd_step) state <= STEP;
                end
                RUN: begin
                    if (halt_hit) begin
                        state    <= HALT;
                        halted_q <= 1'b1;
                    end else if (bus.cmd_stop) begin
                        state <= IDLE;
                    end
                end
                STEP: begin
                    if (halt_hit) begin
                        state    <= HALT;
                        halted_q <= 1'b1;
                    end else if (adv) begin
                        state <= IDLE;
                    end
                end
                HALT: ;
            endcase
        end
    end

    assign bus.if_id_data[IFID_PC4_HI:IFID_PC4_LO]     = 32'(pc_plus4);
    assign bus.if_id_data[IFID_INSTR_HI:IFID_INSTR_LO] = instr;
    assign bus.if_id_we    = adv;
    assign bus.if_id_flush = redir;
    assign bus.pc          = pc_q;
    assign bus.halted      = halted_q;

`ifdef IF_FETCH_CNT_EN
    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (!reset)   count_q <= '0;
        else if (adv) count_q <= count_q + 32'd1;
    end

    assign bus.fetch_count = count_q;
`else
    assign bus.fetch_count = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus randomized traffic against a reference model.
module tb_instruction_fetch_unit;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 256;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instruction_fetch_unit_if #(.PC_W(PC_W), .IMEM_AW(AW)) bus ();

    instruction_fetch_unit #(.PC_W(PC_W), .IMEM_AW(AW), .HALT_OPCODE(6'h3F)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef enum int {M_IDLE, M_RUN, M_STEP, M_HALT} mode_t;

    mode_t       m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic [31:0] m_mem [DEPTH];
    int unsigned vectors    = 0;
    int unsigned miscompares = 0;
    int unsigned halt_age   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_instr();
        return m_mem[(m_pc >> 2) % DEPTH];
    endfunction

    function automatic logic [31:0] exp_count();
`ifdef IF_FETCH_CNT_EN
        return m_cnt;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] nop_word();
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] == 6'h3F) w[31:26] = 6'h08;
        return w;
    endfunction

    task automatic check_outputs();
        bit fetching;
        fetching = (m_mode == M_RUN) || (m_mode == M_STEP);
        check_eq("pc", 64'(bus.pc), 64'(m_pc));
        check_eq("halted", 64'(bus.halted), 64'(m_mode == M_HALT));
        check_eq("fetch_count", 64'(bus.fetch_count), 64'(exp_count()));
        if (reset) begin
            check_eq("if_id_we", 64'(bus.if_id_we),
                     64'(fetching && !bus.stall && !bus.redirect_valid));
            check_eq("if_id_flush", 64'(bus.if_id_flush), 64'(fetching && bus.redirect_valid));
            check_eq("if_id_data", bus.if_id_data, {m_pc + 32'd4, m_instr()});
        end
    endtask

    // Reference behaviour at a clock edge, from the current inputs.
    task automatic model_edge();
        bit fetching, go, hit;
        fetching = (m_mode == M_RUN) || (m_mode == M_STEP);
        go       = fetching && !bus.stall && !bus.redirect_valid;
        hit      = go && (m_instr() >> 26) == 32'h3F;
        if (m_mode == M_IDLE && bus.load_we) m_mem[bus.load_addr] = bus.load_data;
        if (!reset) begin
            m_mode = M_IDLE;
            m_pc   = 32'd0;
            m_cnt  = 32'd0;
            return;
        end
        if (go) m_cnt = m_cnt + 32'd1;
        if (fetching && bus.redirect_valid) m_pc = bus.redirect_pc;
        else if (go && !hit) m_pc = m_pc + 32'd4;
        if (hit) m_mode = M_HALT;
        else begin
            case (m_mode)
                M_IDLE: if (bus.cmd_run) m_mode = M_RUN; else if (bus.cmd_step) m_mode = M_STEP;
                M_RUN:  if (bus.cmd_stop) m_mode = M_IDLE;
                M_STEP: if (go) m_mode = M_IDLE;
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.cmd_run = 0; bus.cmd_step = 0; bus.cmd_stop = 0;
        bus.load_we = 0; bus.load_addr = '0; bus.load_data = '0;
        bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 0;
        tick();
        reset = 1;
    endtask

    task automatic load_word(input int unsigned addr, input logic [31:0] data);
        bus.load_we = 1; bus.load_addr = AW'(addr); bus.load_data = data;
        tick();
        bus.load_we = 0;
    endtask

    initial begin
        logic [31:0] stall_pat;
        clear_inputs();
        reset  = 0;
        m_mode = M_IDLE; m_pc = 0; m_cnt = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
        @(negedge clk);
        tick();
        reset = 1;
        #1;
        check_eq("reset_pc", 64'(bus.pc), 64'd0);
        check_eq("reset_halted", 64'(bus.halted), 64'd0);
        check_eq("reset_count", 64'(bus.fetch_count), 64'd0);

        for (int i = 0; i < DEPTH; i++) load_word(i, nop_word());
        load_word(0, 32'h20010005);
        load_word(1, 32'h20020007);
        load_word(2, 32'hFC000000);

        // Run into the halt word.
        bus.cmd_run = 1; tick(); bus.cmd_run = 0;
        check_eq("tp1_word0", bus.if_id_data, 64'h00000004_20010005);
        tick();
        check_eq("tp1_word1", bus.if_id_data, 64'h00000008_20020007);
        tick();
        check_eq("tp1_word2", bus.if_id_data, 64'h0000000C_FC000000);
        #1 check_eq("tp1_halt_we", 64'(bus.if_id_we), 64'd1);
        tick();
        check_eq("tp1_halted", 64'(bus.halted), 64'd1);
        check_eq("tp1_pc_hold", 64'(bus.pc), 64'h8);
        bus.cmd_run = 1; bus.cmd_step = 1; bus.redirect_valid = 1; bus.redirect_pc = 32'h40;
        #1 check_eq("halt_flush_ignored", 64'(bus.if_id_flush), 64'd0);
        tick(); tick();
        do_reset();

        // Two single steps with idle gaps.
        bus.cmd_step = 1; tick(); bus.cmd_step = 0;
        #1 check_eq("step1_we", 64'(bus.if_id_we), 64'd1);
        tick();
        check_eq("step1_pc", 64'(bus.pc), 64'h4);
        #1 check_eq("step1_idle_we", 64'(bus.if_id_we), 64'd0);
        tick(); tick(); tick();
        bus.cmd_step = 1; tick(); bus.cmd_step = 0;
        tick();
        check_eq("step2_pc", 64'(bus.pc), 64'h8);

        // Stall at 0x10, then redirect under stall.
        load_word(2, nop_word());
        do_reset();
        bus.cmd_run = 1; tick(); bus.cmd_run = 0;
        repeat (4) tick();
        bus.stall = 1;
        repeat (3) begin
            #1 check_eq("stall_we", 64'(bus.if_id_we), 64'd0);
            tick();
            check_eq("stall_pc", 64'(bus.pc), 64'h10);
        end
        bus.redirect_valid = 1; bus.redirect_pc = 32'h40;
        #1 check_eq("redir_flush", 64'(bus.if_id_flush), 64'd1);
        check_eq("redir_we", 64'(bus.if_id_we), 64'd0);
        tick();
        clear_inputs();
        #1 check_eq("redir_target", 64'(bus.if_id_data[63:32]), 64'h44);

        // Load ignored while running; reset mid-run keeps the program.
        bus.load_we = 1; bus.load_addr = 8'h20; bus.load_data = 32'hFC000000;
        tick();
        clear_inputs();
        reset = 0; tick(); reset = 1;
        check_eq("midreset_pc", 64'(bus.pc), 64'd0);
        check_eq("midreset_halted", 64'(bus.halted), 64'd0);
        check_eq("midreset_count", 64'(bus.fetch_count), 64'd0);
        check_eq("midreset_mem", bus.if_id_data, 64'h00000004_20010005);

        // Five fetches and two stalls.
        bus.cmd_run = 1; tick(); bus.cmd_run = 0;
        stall_pat = 32'b0010010;
        for (int i = 0; i < 7; i++) begin
            bus.stall    = stall_pat[i];
            bus.cmd_stop = (i == 6);
            tick();
        end
        clear_inputs();
`ifdef IF_FETCH_CNT_EN
        check_eq("count_5", 64'(bus.fetch_count), 64'd5);
`else
        check_eq("count_off", 64'(bus.fetch_count), 64'd0);
`endif

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            clear_inputs();
            halt_age = (m_mode == M_HALT) ? halt_age + 1 : 0;
            if (halt_age > 4 || $urandom_range(0, 199) == 0) begin
                reset = 0;
            end else begin
                reset = 1;
                bus.cmd_run        = ($urandom_range(0, 5) == 0);
                bus.cmd_step       = ($urandom_range(0, 5) == 0);
                bus.cmd_stop       = ($urandom_range(0, 9) == 0);
                bus.stall          = ($urandom_range(0, 3) == 0);
                bus.redirect_valid = ($urandom_range(0, 7) == 0);
                case ($urandom_range(0, 15))
                    0:       bus.redirect_pc = 32'hFFFF_FFFC;
                    1:       bus.redirect_pc = $urandom;
                    default: bus.redirect_pc = $urandom & 32'h3FC;
                endcase
                bus.load_we   = ($urandom_range(0, 5) == 0);
                bus.load_addr = AW'($urandom);
                bus.load_data = ($urandom_range(0, 15) == 0) ? 32'hFC000000 | ($urandom & 32'h03FF_FFFF)
                                                              : nop_word();
            end
            tick();
        end
        reset = 1;
        clear_inputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Pipeline IF stage of the MIPS core: owns the PC, the program instruction memory and the debug run-control FSM.
- Produces the 64-bit {pc_plus4, instruction} word plus its write-enable and flush for the IF/ID pipeline register directly downstream.
- Program load, run, single-step and stop are driven by the debug unit; branch/jump redirects and load-use stalls come from ID/hazard logic.

Parameters:
- PC_W, 32, PC and address width in bits.
- IMEM_AW, 8, instruction memory word-address width (depth = 2**IMEM_AW words).
- HALT_OPCODE, 6'h3F, opcode field value (instr[31:26]) that halts fetch.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-low.
- cmd_run  input  1  debug: start continuous fetch.
- cmd_step  input  1  debug: fetch exactly one instruction.
- cmd_stop  input  1  debug: pause continuous fetch.
- load_we  input  1  debug: program-load write strobe.
- load_addr  input  IMEM_AW  program-load word address.
- load_data  input  32  program-load instruction word.
- stall  input  1  hazard unit: hold PC and IF/ID contents.
- redirect_valid  input  1  taken branch/jump from ID.
- redirect_pc  input  PC_W  branch/jump target, byte address.
- if_id_data  output  64  {pc+4[31:0], instr[31:0]} to IF/ID.
- if_id_we  output  1  IF/ID write enable.
- if_id_flush  output  1  IF/ID clear, active-high.
- pc  output  PC_W  current PC, for debug readout.
- halted  output  1  HALT state indicator.
- fetch_count  output  32  number of advancing fetches (optional feature).

Behaviour:
- Reset (reset==0 at posedge):
  - pc=0, state=IDLE, halted=0, fetch_count=0.
  - Instruction memory contents are not cleared.
- Memory:
  - Combinational read: instr = mem[pc[IMEM_AW+1:2]]. PC bits above the memory index and the low 2 bits are ignored, so addresses wrap modulo the depth.
  - Write on posedge when load_we=1, and only while state==IDLE; load_we is ignored in any other state.
- FSM states: IDLE, RUN, STEP, HALT.
  - IDLE: cmd_run -> RUN. cmd_step -> STEP. Simultaneous run and step: run wins.
  - RUN: cmd_stop -> IDLE (the fetch in the same cycle still completes).
  - STEP: after the first advancing cycle -> IDLE. Stays in STEP while stall=1.
  - HALT: terminal; all commands ignored; exit only by reset.
  - cmd_run/cmd_step/cmd_stop in states other than those listed are ignored.
- Advance: adv = (state==RUN || state==STEP) && !stall && !redirect_valid.
- if_id_we = adv. if_id_data is combinational: {pc+4, instr}.
- PC update:
  - adv: pc <= pc+4, modulo 2**PC_W.
  - stall with no redirect: pc holds, if_id_we=0.
- Redirect, honoured only in RUN or STEP:
  - Takes priority over stall and over halt detection.
  - pc <= redirect_pc; if_id_flush=1 and if_id_we=0 in that cycle. Latency is 1 cycle to the target fetch.
  - In STEP, a redirect does not consume the step.
  - In IDLE or HALT, redirect is ignored and if_id_flush=0.
- Halt:
  - When adv and instr[31:26]==HALT_OPCODE: the halt word is written to IF/ID (if_id_we=1), pc does not increment, and state -> HALT.
  - halted=1 from the next cycle; if_id_we=0 thereafter.
- cmd_stop and halt detected in the same cycle: HALT wins.

Optional Feature:
- Macro IF_FETCH_CNT_EN.
- Defined: fetch_count increments on every cycle with adv=1 (including the halt fetch), wraps at 2**32, and clears on reset.
- Undefined: the counter is not built and fetch_count is tied to 0; the port is always present.

Decomposition:
- Package if_pkg: FSM state enum (IDLE, RUN, STEP, HALT), HALT_OPCODE default, PC_RESET value 0, IF/ID word layout constants (pc+4 field 63:32, instr field 31:0).
- One sub-module instr_mem: synchronous-write, combinational-read word RAM parameterised by IMEM_AW.

Test Plan:
- Load at addr 0..2 with 0x20010005, 0x20020007, 0xFC000000; cmd_run -> if_id_data = 0x00000004_20010005, then 0x00000008_20020007, then 0x0000000C_FC000000; halted=1 one cycle later; pc stays 0x8.
- IDLE, cmd_step twice with 3 idle cycles between -> exactly two cycles with if_id_we=1; pc 0 -> 4 -> 8; state back to IDLE each time.
- RUN with stall=1 for 3 cycles at pc=0x10 -> if_id_we=0, pc holds 0x10; fetch resumes at 0x10 after stall drops.
- RUN, redirect_valid=1 with redirect_pc=0x40 while stall=1 -> if_id_flush=1, if_id_we=0 that cycle; next if_id_data pc+4 field = 0x44.
- load_we=1 during RUN -> memory unchanged; reset=0 mid-RUN -> pc=0, IDLE, halted=0, fetch_count=0 and program retained.
- With IF_FETCH_CNT_EN: 5 advancing cycles plus 2 stalled cycles -> fetch_count=5; without the macro -> 0.
